sram_like_arbiter: RTL

- Two-master to one-slave arbiter for the core's SRAM-like bus.
- Merges the fetch (inst_*) and execute/writeback (data_*) request channels onto a single mem_* port, which feeds the cache/AXI bridge.
- Tracks outstanding requests in an in-order source FIFO and steers each mem_data_ok back to the master that issued the request.
- Never reorders responses.

---
 rtl/sram_like_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// Two-master (fetch/data) to one-slave SRAM-like bus arbiter with in-order response steering.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin instead of data-first priority.
module sram_like_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic [31:0]      inst_addr,
  output logic             inst_addr_ok,
  output logic [31:0]      inst_rdata,
  output logic             inst_data_ok,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [3:0]       data_wstrb,
  input  logic [2:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic [31:0]      data_rdata,
  output logic             data_data_ok,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [3:0]       mem_wstrb,
  output logic [2:0]       mem_size,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_data_ok,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             spurious_o
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic             lock_src_reg;
  logic             grant;
  logic             idle_pick;
  logic             sel_req;
  logic             push, pop;
  logic             head;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             spurious_reg;
  logic             src_mem [DEPTH];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_reg;

  // With both masters asking, the one not served last time wins.
  always_comb begin
    if (data_req && inst_req) idle_pick = ~last_grant_reg;
    else                      idle_pick = data_req ? SRC_DATA : SRC_INST;
  end

  always_ff @(posedge clk) begin
    if (!resetn)   last_grant_reg <= SRC_INST;
    else if (push) last_grant_reg <= grant;
  end
`else
  // The data request belongs to the older instruction, so it goes first.
  always_comb idle_pick = data_req ? SRC_DATA : SRC_INST;
`endif

  always_comb begin
    state_next = state_reg;
    grant      = (state_reg == LOCKED) ? lock_src_reg : idle_pick;
    sel_req    = (grant == SRC_DATA) ? data_req : inst_req;
    mem_req    = sel_req && (count_reg != FULL);
    if (mem_req && !mem_addr_ok)     state_next = LOCKED;
    else if (mem_req && mem_addr_ok) state_next = IDLE;

    mem_wr    = 1'b0;
    mem_wstrb = 4'h0;
    mem_size  = 3'd2;
    mem_addr  = inst_addr;
    mem_wdata = 32'h0;
    if (grant == SRC_DATA) begin
      mem_wr    = data_wr;
      mem_wstrb = data_wstrb;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end

    push         = mem_req && mem_addr_ok;
    pop          = mem_data_ok && (count_reg != '0);
    inst_addr_ok = push && (grant == SRC_INST);
    data_addr_ok = push && (grant == SRC_DATA);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      lock_src_reg <= SRC_INST;
    end else begin
      state_reg <= state_next;
      if (mem_req && !mem_addr_ok) lock_src_reg <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (push) src_mem[wr_ptr_reg] <= grant;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      spurious_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      if (mem_data_ok && count_reg == '0) spurious_reg <= 1'b1;
    end
  end

  assign head          = src_mem[rd_ptr_reg];
  assign inst_rdata    = mem_rdata;
  assign data_rdata    = mem_rdata;
  assign inst_data_ok  = pop && (head == SRC_INST);
  assign data_data_ok  = pop && (head == SRC_DATA);
  assign outstanding_o = count_reg;
  assign spurious_o    = spurious_reg;

endmodule
